alu_seq: RTL and testbench

Parametrised, registered successor to the team's 4-bit combinational ALU. It performs one operation per accepted command on WIDTH-bit operands, with valid/ready handshakes on input and output. Single-cycle ops complete with 1-cycle latency; MUL is a multi-cycle shift-add sequence. It sits between an operand-issue stage and a result-writeback stage in the datapath.

---
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Ports: clk, rst_n, in_valid/in_ready/A/B/sel in, out_valid/out_ready/result/carry_out/overflow/zero/busy out.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;

  assign in_ready  = rst_n &&
                     ((state_q == S_IDLE) ||
                      ((state_q == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Bit WIDTH of the widened shift is A[WIDTH-shamt], or 0 for shamt 0.
  assign sum_w = {1'b0, A} + {1'b0, B};
  assign dif_w = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
  assign shl_w = {1'b0, A} << B[SW-1:0];

  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (sel)
      OP_ADD: begin
        op_res = sum_w[WIDTH-1:0];
        op_c   = sum_w[WIDTH];
        op_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                 (sum_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = dif_w[WIDTH-1:0];
        op_c   = dif_w[WIDTH];
        op_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                 (dif_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: op_res = A & B;
      OP_OR:  op_res = A | B;
      OP_XOR: op_res = A ^ B;
      OP_NOT: op_res = ~A;
      OP_SHL: begin
        op_res = shl_w[WIDTH-1:0];
        op_c   = shl_w[WIDTH];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (1'b1)
      (state_q == S_BUSY): begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = acc_d[WIDTH-1:0];
          carry_d  = |acc_d[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          zero_d   = (acc_d[WIDTH-1:0] == '0);
        end
      end
      default: begin
        if ((state_q == S_DONE) && out_ready)
          state_d = S_IDLE;
        if (accept) begin
          if (sel == 3'b111) begin
            state_d  = S_BUSY;
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
          end else begin
            state_d  = S_DONE;
            result_d = op_res;
            carry_d  = op_c;
            ovf_d    = op_v;
            zero_d   = (op_res == '0);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=4 and WIDTH=8.
// Two instances share the clock; each has its own reset and handshake.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic       rst4_n, iv4, ir4, ov4, or4, c4, v4, z4, bz4;
  logic [3:0] a4, b4, r4;
  logic [2:0] s4;

  logic       rst8_n, iv8, ir8, ov8, or8, c8, v8, z8, bz8;
  logic [7:0] a8, b8, r8;
  logic [2:0] s8;

  alu_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst4_n),
    .in_valid(iv4), .in_ready(ir4),
    .A(a4), .B(b4), .sel(s4),
    .out_valid(ov4), .out_ready(or4),
    .result(r4), .carry_out(c4),
    .overflow(v4), .zero(z4), .busy(bz4)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst8_n),
    .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .sel(s8),
    .out_valid(ov8), .out_ready(or8),
    .result(r8), .carry_out(c8),
    .overflow(v8), .zero(z8), .busy(bz8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd4(input logic [2:0] s,
                      input logic [3:0] a,
                      input logic [3:0] b);
    iv4 = 1'b1; s4 = s; a4 = a; b4 = b;
  endtask

  task automatic cmd8(input logic [2:0] s,
                      input logic [7:0] a,
                      input logic [7:0] b);
    iv8 = 1'b1; s8 = s; a8 = a; b8 = b;
  endtask

  initial begin
    rst4_n = 1'b0; rst8_n = 1'b0;
    iv4 = 1'b1; a4 = 4'h3; b4 = 4'h2; s4 = 3'b000; or4 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 3'b000; or8 = 1'b1;
    step(); step();
    chk("rst_in_ready", ir4, 0);
    chk("rst_out_valid", ov4, 0);
    chk("rst_result", r4, 0);
    chk("rst_flags", {c4, v4, z4, bz4}, 0);
    iv4 = 1'b0;
    rst4_n = 1'b1; rst8_n = 1'b1;
    #1;
    chk("rel_in_ready", ir4, 1);
    step();
    chk("idle_out_valid", ov4, 0);

    // ADD, then back-to-back SUB, SUB, NOT, OR
    cmd4(3'b000, 4'b0101, 4'b0011);
    step();
    chk("add_valid", ov4, 1);
    chk("add_res", r4, 4'b1000);
    chk("add_cvz", {c4, v4, z4}, 3'b010);
    cmd4(3'b001, 4'b0101, 4'b0011);
    chk("add_in_ready", ir4, 1);
    step();
    chk("sub_valid", ov4, 1);
    chk("sub_res", r4, 4'b0010);
    chk("sub_cvz", {c4, v4, z4}, 3'b100);
    cmd4(3'b001, 4'b0101, 4'b0101);
    step();
    chk("subeq_res", r4, 4'b0000);
    chk("subeq_cvz", {c4, v4, z4}, 3'b101);
    cmd4(3'b101, 4'b0101, 4'b0000);
    step();
    chk("not_res", r4, 4'b1010);
    chk("not_cvz", {c4, v4, z4}, 3'b000);
    cmd4(3'b011, 4'b0101, 4'b0011);
    step();
    chk("or_res", r4, 4'b0111);
    iv4 = 1'b0;
    step();
    chk("drain_out_valid", ov4, 0);

    // MUL 5*3
    cmd4(3'b111, 4'd5, 4'd3);
    step();
    iv4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy", bz4, 1);
      chk("mul_in_ready", ir4, 0);
      chk("mul_no_valid", ov4, 0);
      step();
    end
    chk("mul_valid", ov4, 1);
    chk("mul_busy_low", bz4, 0);
    chk("mul_res", r4, 4'hF);
    chk("mul_cvz", {c4, v4, z4}, 3'b000);

    // MUL 15*15 accepted from DONE
    cmd4(3'b111, 4'd15, 4'd15);
    step();
    iv4 = 1'b0;
    chk("mul2_busy", bz4, 1);
    step(); step(); step();
    chk("mul2_not_yet", ov4, 0);
    step();
    chk("mul2_valid", ov4, 1);
    chk("mul2_res", r4, 4'h1);
    chk("mul2_cvz", {c4, v4, z4}, 3'b100);
    step();

    // Backpressure after XOR
    cmd4(3'b100, 4'hC, 4'hA);
    step();
    chk("xor_res", r4, 4'h6);
    or4 = 1'b0;
    cmd4(3'b010, 4'h3, 4'h5);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", ir4, 0);
      step();
      chk("bp_valid", ov4, 1);
      chk("bp_res", r4, 4'h6);
      chk("bp_cvz", {c4, v4, z4}, 3'b000);
    end
    or4 = 1'b1;
    #1;
    chk("bp_release_ready", ir4, 1);
    step();
    iv4 = 1'b0;
    chk("and_res", r4, 4'h1);
    chk("and_valid", ov4, 1);
    step();

    // WIDTH=8: SHL and MUL
    cmd8(3'b110, 8'h81, 8'd1);
    step();
    chk("shl1_res", r8, 8'h02);
    chk("shl1_c", c8, 1);
    cmd8(3'b110, 8'h81, 8'd8);
    step();
    chk("shl0_res", r8, 8'h81);
    chk("shl0_c", c8, 0);
    cmd8(3'b110, 8'h81, 8'd7);
    step();
    chk("shl7_res", r8, 8'h80);
    chk("shl7_c", c8, 0);
    cmd8(3'b111, 8'd200, 8'd3);
    step();
    iv8 = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mul8_not_yet", ov8, 0);
    step();
    chk("mul8_valid", ov8, 1);
    chk("mul8_res", r8, 8'h58);
    chk("mul8_c", c8, 1);
    step();

    // Reset mid-MUL
    cmd8(3'b111, 8'd7, 8'd9);
    step();
    iv8 = 1'b0;
    step(); step();
    chk("pre_rst_busy", bz8, 1);
    #2;
    rst8_n = 1'b0;
    #1;
    chk("rst_busy_drop", bz8, 0);
    chk("rst_valid_drop", ov8, 0);
    chk("rst_in_ready8", ir8, 0);
    step();
    rst8_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (ov8 || bz8) seen = 1'b1;
      end
      chk("no_stale_result", seen, 0);
    end
    chk("post_rst_res", r8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
